// File: rtl/sort_read_master_pkg.sv
// rtl/sort_read_master_pkg.sv - shared types, default widths and helpers for the sort read master
// Purpose: FSM state encoding, default parameter values and the address stride helper
//          used by the read master, its FIFO and its bus interface.
// Ports:   none (package).
package sort_read_master_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Byte distance between consecutive words on the bus.
  function automatic int addr_stride(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sort_read_master_if.sv
// rtl/sort_read_master_if.sv - Avalon-MM read bus plus sorter stream bundle
// Purpose: groups the Avalon-MM master signals and the valid/ready output stream.
// Ports (master view):
//   m_address/m_read out, m_waitrequest/m_readdata/m_readdatavalid in,
//   out_data/out_valid out, out_ready in. The slave modport is the mirror image.
interface sort_read_master_if
  import sort_read_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output m_address, m_read,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  m_address, m_read,
    output m_waitrequest, m_readdata, m_readdatavalid,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/sort_fifo.sv
// rtl/sort_fifo.sv - synchronous first-word fall-through FIFO for returned read data
// Purpose: buffers read beats; rd_data always shows the head entry while !empty.
// Ports:
//   clock, reset (async active-high)
//   wr_en, wr_data   push side (push while full is accepted only together with a pop)
//   rd_en, rd_data   pop side (rd_en while empty is ignored)
//   empty, full, count  occupancy status
module sort_fifo
  import sort_read_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  always_comb begin
    pop      = rd_en && (count_q != '0);
    // A full FIFO can still take a write when the head leaves in the same cycle.
    push     = wr_en && ((count_q != CNT_W'(DEPTH)) || pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;

endmodule

// File: rtl/sort_read_master.sv
// rtl/sort_read_master.sv - Avalon-MM read master streaming a word block to the sorter
// Purpose: on start, issues pipelined reads from base_addr for word_count words,
//          buffers returns in a FIFO and presents them on a valid/ready stream.
// Ports:
//   clock, reset (async active-high)
//   start, base_addr, word_count   transfer request (sampled when idle)
//   busy, done                     transfer status; done is a 1-cycle pulse
//   bus (master)                   Avalon-MM read bus and output stream
module sort_read_master
  import sort_read_master_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   word_count,
  output logic               busy,
  output logic               done,
  sort_read_master_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(addr_stride(DATA_W));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  received_q, received_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              credit_ok;
  logic              read_req;
  logic              accept;
  logic              beat;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;

    // Every request in flight owns a FIFO slot, so returns can never overflow.
    // The sum can only shrink while a request is stalled, which keeps m_read
    // stable under waitrequest.
    credit_ok = !fifo_full &&
                ((SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    read_req  = (state_q == ST_ISSUE) && credit_ok;
    accept    = read_req && !bus.m_waitrequest;
    beat      = bus.m_readdatavalid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    if (accept) begin
      addr_d   = addr_q + STRIDE;
      issued_d = issued_q + LEN_W'(1);
    end
    if (beat) begin
      received_d = received_q + LEN_W'(1);
    end
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(beat);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d        = base_addr;
          len_d         = word_count;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          state_d       = (word_count == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept && ((issued_q + LEN_W'(1)) == len_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finish only once the sorter has taken the last word.
        if ((received_q == len_q) && fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
    end
  end

  sort_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (beat),
    .wr_data (bus.m_readdata),
    .rd_en   (bus.out_ready),
    .rd_data (bus.out_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign bus.m_read    = read_req;
  assign bus.m_address = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign busy          = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_sort_read_master.sv
// tb/tb_sort_read_master.sv - directed vector bench for sort_read_master
module tb_sort_read_master;

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    int          wait_idx;
    int          wait_len;
    int          ready_hold;
    int          restart_at;
    int          exp_acc_hold;
    int          exp_done_cyc;
    logic [31:0] exp_last_addr;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy;
  logic        done;

  logic        pv0, pv1;
  logic [31:0] pd0, pd1;

  int n_vec = 0;
  int n_bad = 0;

  vec_t vecs[6];

  sort_read_master_if bus ();

  sort_read_master dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, n_acc, n_pop, done_cnt, done_cyc, first_rd, hold_left;
    logic [31:0] last_addr;
    logic acc, wait_active;
    cyc = 0; n_acc = 0; n_pop = 0; done_cnt = 0; done_cyc = -1; first_rd = -1;
    hold_left = v.wait_len;
    last_addr = '0;
    pv0 = 1'b0; pv1 = 1'b0; pd0 = '0; pd1 = '0;
    while (1) begin
      @(negedge clock);
      start      = (cyc == 0) || (cyc == v.restart_at);
      base_addr  = (cyc == 0) ? v.base : 32'h0000_7000;
      word_count = (cyc == 0) ? v.cnt : 16'd9;
      bus.out_ready = (cyc >= v.ready_hold);
      if (v.ready_hold > 0 && cyc == v.ready_hold) begin
        check($sformatf("v%0d accepts_under_backpressure", idx), 32'(n_acc), 32'(v.exp_acc_hold));
        check($sformatf("v%0d m_read_dropped", idx), 32'(bus.m_read), 32'd0);
      end
      wait_active = (hold_left > 0) && (hold_left < v.wait_len);
      if (wait_active)
        check($sformatf("v%0d m_read_held", idx), 32'(bus.m_read), 32'd1);
      if (hold_left > 0 && (wait_active || (bus.m_read && n_acc == v.wait_idx))) begin
        bus.m_waitrequest = 1'b1;
        hold_left--;
        check($sformatf("v%0d addr_held", idx), bus.m_address, v.base + 32'(n_acc * 4));
      end else begin
        bus.m_waitrequest = 1'b0;
      end
      bus.m_readdatavalid = pv1;
      bus.m_readdata      = pd1;
      #1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.m_read && first_rd < 0) first_rd = cyc;
      acc = bus.m_read && !bus.m_waitrequest;
      if (acc) begin
        check($sformatf("v%0d addr[%0d]", idx, n_acc), bus.m_address, v.base + 32'(n_acc * 4));
        last_addr = bus.m_address;
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("v%0d data[%0d]", idx, n_pop), bus.out_data, mem_word(v.base + 32'(n_pop * 4)));
        n_pop++;
      end
      pv1 = pv0; pd1 = pd0;
      pv0 = acc; pd0 = acc ? mem_word(bus.m_address) : 32'h0;
      cyc++;
      if (done_cnt > 0 && cyc > done_cyc + 2) break;
      if (cyc > 600) begin
        n_vec++;
        n_bad++;
        $display("FAIL v%0d timeout: got no done within %0d cycles expected done", idx, cyc);
        break;
      end
    end
    start = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.m_waitrequest = 1'b0;
    check($sformatf("v%0d accept_count", idx), 32'(n_acc), 32'(v.cnt));
    check($sformatf("v%0d word_count_out", idx), 32'(n_pop), 32'(v.cnt));
    check($sformatf("v%0d done_pulses", idx), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d busy_after", idx), 32'(busy), 32'd0);
    if (v.exp_done_cyc >= 0)
      check($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'(v.exp_done_cyc));
    if (v.cnt != 0) begin
      check($sformatf("v%0d first_read_cycle", idx), 32'(first_rd), 32'd1);
      check($sformatf("v%0d last_addr", idx), last_addr, v.exp_last_addr);
    end
  endtask

  initial begin
    int n;
    //            base          cnt  widx wlen hold rst  acc8 donec last
    vecs[0] = '{32'h0000_1000, 16'd4,  -1, 0,  0,  -1,  0,   9,  32'h0000_100C};
    vecs[1] = '{32'h0000_1000, 16'd4,   1, 3,  0,  -1,  0,  -1,  32'h0000_100C};
    vecs[2] = '{32'h0000_2000, 16'd20, -1, 0,  30, -1,  8,  -1,  32'h0000_204C};
    vecs[3] = '{32'h0000_5000, 16'd0,  -1, 0,  0,  -1,  0,   1,  32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFC, 16'd2,  -1, 0,  0,   1,  0,  -1,  32'h0000_0000};
    vecs[5] = '{32'h0000_4000, 16'd3,  -1, 0,  0,  -1,  0,  -1,  32'h0000_4008};

    bus.m_waitrequest   = 1'b0;
    bus.m_readdata      = '0;
    bus.m_readdatavalid = 1'b0;
    bus.out_ready       = 1'b1;

    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_m_read", 32'(bus.m_read), 32'd0);
    check("reset_m_address", bus.m_address, 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Return beat while idle must not land in the FIFO.
    @(negedge clock);
    bus.m_readdatavalid = 1'b1;
    bus.m_readdata      = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.m_readdatavalid = 1'b0;
    #1;
    check("idle_rdv_ignored", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of a 10-word transfer.
    @(negedge clock);
    start = 1'b1; base_addr = 32'h0000_3000; word_count = 16'd10;
    bus.out_ready = 1'b0;
    n = 0;
    for (int c = 1; c < 40 && n < 3; c++) begin
      @(negedge clock);
      start = 1'b0;
      bus.m_readdatavalid = (c >= 2);
      bus.m_readdata = 32'h1111_0000 + 32'(c);
      #1;
      if (bus.m_read && !bus.m_waitrequest) n++;
    end
    check("midop_three_issued", 32'(n), 32'd3);
    @(posedge clock);
    #1;
    check("midop_busy_before", 32'(busy), 32'd1);
    check("midop_out_valid_before", 32'(bus.out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midop_busy", 32'(busy), 32'd0);
    check("midop_done", 32'(done), 32'd0);
    check("midop_m_read", 32'(bus.m_read), 32'd0);
    check("midop_m_address", bus.m_address, 32'd0);
    check("midop_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.out_ready = 1'b1;

    run_vec(vecs[5], 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
